// File: rtl/scanner_rx_pkg.sv
// Shared definitions for the scanner capture controller: register map, bit positions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package scanner_rx_pkg;

    // Avalon register offsets
    localparam logic [1:0] ADDR_DATA      = 2'd0;
    localparam logic [1:0] ADDR_STATUS    = 2'd1;
    localparam logic [1:0] ADDR_CONTROL   = 2'd2;
    localparam logic [1:0] ADDR_FRAME_LEN = 2'd3;

    // STATUS bit positions
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_UDF     = 3;
    localparam int STAT_DONE    = 4;
    localparam int STAT_RUN     = 5;
    localparam int STAT_CNT_LSB = 8;
    localparam int STAT_CNT_MSB = 16;

    // CONTROL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_FLUSH  = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/scanner_rx_fifo.sv
// Generic synchronous FIFO with push, pop, flush; head word is shown combinationally from storage.
// Latency: pushed word visible at head and in count one cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty, flush overrides both.
module scanner_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output logic [DATA_W-1:0]        head_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign head_dat = mem[rd_ptr];

    // Storage array; no reset needed since count gates every read
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    // Pointers and occupancy; flush empties the queue in one cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/scanner_rx_ctrl.sv
// Scanner byte capture controller with Avalon-MM register slave; interrupt logic only under SCANNER_RX_IRQ_EN.
// Latency: accepted byte counted one cycle after handshake; readdata one cycle after chipselect&read.
// Backpressure: scan_ready is registered-only, low unless in RUN with FIFO not full.
module scanner_rx_ctrl
    import scanner_rx_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] scan_data,
    input  logic              scan_valid,
    output logic              scan_ready,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t            state_q;
    state_t            state_d;
    logic [CW-1:0]     fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] head_dat;

    logic              rd_en;
    logic              wr_en;
    logic              data_rd;
    logic              pop;
    logic              push;
    logic              flush;
    logic              ctrl_wr;
    logic              stat_wr;
    logic              flen_wr;
    logic              start;
    logic              stop;
    logic              frame_hit;
    logic              ovf_set;
    logic              udf_set;
    logic              done_set;

    logic [7:0]        byte_cnt_q;
    logic [7:0]        cnt_inc;
    logic [7:0]        frame_len_q;
    logic              enable_q;
    logic              ovf_q;
    logic              udf_q;
    logic              done_q;
    logic [31:0]       status_word;
    logic [31:0]       ctrl_word;
    logic [31:0]       rd_mux;
    logic              unused_wdata;

    assign rd_en   = chipselect & read;
    assign wr_en   = chipselect & write;
    assign data_rd = rd_en & (address == ADDR_DATA);
    assign pop     = data_rd & ~fifo_empty;
    assign udf_set = data_rd & fifo_empty;
    assign ctrl_wr = wr_en & (address == ADDR_CONTROL);
    assign stat_wr = wr_en & (address == ADDR_STATUS);
    assign flen_wr = wr_en & (address == ADDR_FRAME_LEN);
    assign flush   = ctrl_wr & writedata[CTRL_FLUSH];

    // Only registered state feeds scan_ready, so no input-to-output path exists
    assign scan_ready = (state_q == RUN) & ~fifo_full;
    assign push       = scan_valid & scan_ready;
    assign ovf_set    = scan_valid & (state_q == RUN) & fifo_full;

    assign cnt_inc   = byte_cnt_q + 8'd1;
    assign frame_hit = push & (frame_len_q != 8'd0) & (cnt_inc == frame_len_q);
    assign start     = ctrl_wr & writedata[CTRL_ENABLE] & (state_q != RUN);
    assign stop      = ctrl_wr & ~writedata[CTRL_ENABLE];
    assign done_set  = (state_q == RUN) & (state_d == DONE);

    assign unused_wdata = &{1'b0, writedata[30:8]};

    scanner_rx_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (push),
        .push_dat (scan_data),
        .pop      (pop),
        .flush    (flush),
        .head_dat (head_dat),
        .count    (fifo_count),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: software control wins over frame completion
    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
        end else if ((state_q == RUN) && frame_hit) begin
            state_d = DONE;
        end
    end

    // Byte counter, configuration and sticky flags (set beats clear)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt_q  <= 8'd0;
            frame_len_q <= 8'd0;
            enable_q    <= 1'b0;
            ovf_q       <= 1'b0;
            udf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            if (start) begin
                byte_cnt_q <= 8'd0;
            end else if (push) begin
                byte_cnt_q <= cnt_inc;
            end
            if (flen_wr) begin
                frame_len_q <= writedata[7:0];
            end
            if (ctrl_wr) begin
                enable_q <= writedata[CTRL_ENABLE];
            end
            ovf_q <= (ovf_q & ~(stat_wr & writedata[STAT_OVF])) | ovf_set;
            udf_q <= (udf_q & ~(stat_wr & writedata[STAT_UDF])) | udf_set;
            if (start) begin
                done_q <= 1'b0;
            end else begin
                done_q <= (done_q & ~(stat_wr & writedata[STAT_DONE])) | done_set;
            end
        end
    end

    // STATUS register image
    always_comb begin
        status_word = '0;
        status_word[STAT_EMPTY] = fifo_empty;
        status_word[STAT_FULL]  = fifo_full;
        status_word[STAT_OVF]   = ovf_q;
        status_word[STAT_UDF]   = udf_q;
        status_word[STAT_DONE]  = done_q;
        status_word[STAT_RUN]   = (state_q == RUN);
        status_word[STAT_CNT_MSB:STAT_CNT_LSB] = 9'(fifo_count);
    end

`ifdef SCANNER_RX_IRQ_EN
    logic irq_en_q;
    logic irq_q;

    // Interrupt enable and registered level interrupt
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                irq_en_q <= writedata[CTRL_IRQ_EN];
            end
            irq_q <= irq_en_q & (done_q | ovf_q);
        end
    end

    assign irq = irq_q;

    // CONTROL register image
    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_ENABLE] = enable_q;
        ctrl_word[CTRL_IRQ_EN] = irq_en_q;
    end
`else
    assign irq = 1'b0;

    // CONTROL register image; interrupt enable does not exist in this build
    always_comb begin
        ctrl_word = '0;
        ctrl_word[CTRL_ENABLE] = enable_q;
    end
`endif

    // Read mux; empty DATA reads return zero
    always_comb begin
        rd_mux = '0;
        case (address)
            ADDR_DATA:    rd_mux = fifo_empty ? 32'd0 : 32'(head_dat);
            ADDR_STATUS:  rd_mux = status_word;
            ADDR_CONTROL: rd_mux = ctrl_word;
            default:      rd_mux = {24'd0, frame_len_q};
        endcase
    end

    // Registered read data, one cycle latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= 32'd0;
        end else if (rd_en) begin
            readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_scanner_rx_ctrl.sv
module tb_scanner_rx_ctrl;

    localparam int DEPTH = 16;

    logic        clk;
    logic        reset_n;
    logic [7:0]  scan_data;
    logic        scan_valid;
    logic        scan_ready;
    logic [1:0]  address;
    logic        chipselect;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    scanner_rx_ctrl #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .address    (address),
        .chipselect (chipselect),
        .read       (read),
        .write      (write),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    byte unsigned q[$];
    bit          m_run;
    bit          m_ovf, m_udf, m_done, m_en, m_irqen;
    int          m_flen, m_cnt;
    logic [31:0] m_rd;
    bit          m_rdv;
    bit          m_irq;

    function automatic bit m_ready();
        return m_run && (q.size() < DEPTH);
    endfunction

    function automatic logic [31:0] m_status();
        return {15'd0, 9'(q.size()), 2'd0, m_run, m_done, m_udf, m_ovf,
                (q.size() == DEPTH), (q.size() == 0)};
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_run = 0; m_ovf = 0; m_udf = 0; m_done = 0; m_en = 0; m_irqen = 0;
            m_flen = 0; m_cnt = 0; m_rdv = 0; m_irq = 0; m_rd = 0;
        end else begin
            bit rd_s, wr_s, push, pop, hit, start, stop, ovf_s, udf_s;
            logic [31:0] wd;
            rd_s = chipselect && read;
            wr_s = chipselect && write;
            wd   = writedata;
            push = scan_valid && m_ready();
            pop  = 0;
            udf_s = 0;
            hit  = 0;
`ifdef SCANNER_RX_IRQ_EN
            m_irq = m_irqen && (m_done || m_ovf);
`else
            m_irq = 0;
`endif
            m_rdv = rd_s;
            if (rd_s) begin
                case (address)
                    2'd0: if (q.size() > 0) begin m_rd = 32'(q[0]); pop = 1; end
                          else begin m_rd = 0; udf_s = 1; end
                    2'd1: m_rd = m_status();
                    2'd2: m_rd = {30'd0, m_irqen, m_en};
                    default: m_rd = 32'(m_flen);
                endcase
            end
            ovf_s = scan_valid && m_run && (q.size() == DEPTH);
            if (wr_s && address == 2'd2 && wd[31]) q.delete();
            else begin
                if (pop)  void'(q.pop_front());
                if (push) q.push_back(scan_data);
            end
            if (push) begin
                m_cnt = (m_cnt + 1) % 256;
                hit = (m_flen != 0) && (m_cnt == m_flen);
            end
            if (wr_s && address == 2'd1) begin
                if (wd[2]) m_ovf = 0;
                if (wd[3]) m_udf = 0;
                if (wd[4]) m_done = 0;
            end
            if (ovf_s) m_ovf = 1;
            if (udf_s) m_udf = 1;
            stop  = wr_s && address == 2'd2 && !wd[0];
            start = wr_s && address == 2'd2 && wd[0] && !m_run;
            if (stop) m_run = 0;
            else if (start) begin m_run = 1; m_cnt = 0; m_done = 0; end
            else if (hit) begin m_run = 0; m_done = 1; end
            if (wr_s && address == 2'd2) begin
                m_en = wd[0];
`ifdef SCANNER_RX_IRQ_EN
                m_irqen = wd[1];
`endif
            end
            if (wr_s && address == 2'd3) m_flen = int'(wd[7:0]);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        chk("scan_ready", {31'd0, scan_ready}, {31'd0, m_ready()});
        chk("irq", {31'd0, irq}, {31'd0, m_irq});
        if (m_rdv) chk("readdata", readdata, m_rd);
    end

    // ---------------- stimulus ----------------
    task automatic avl_wr(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1; write = 1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 0; write = 0;
    endtask

    task automatic avl_rd(input logic [1:0] a, output logic [31:0] d);
        chipselect = 1; read = 1; address = a;
        @(negedge clk);
        chipselect = 0; read = 0;
        d = readdata;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  tbl [4];
        tbl[0] = 8'h11; tbl[1] = 8'h22; tbl[2] = 8'h33; tbl[3] = 8'h44;
        reset_n = 0; scan_data = 0; scan_valid = 0; address = 0;
        chipselect = 0; read = 0; write = 0; writedata = 0;
        repeat (3) @(negedge clk);
        chk("rst_readdata", readdata, 32'd0);
        chk("rst_scan_ready", {31'd0, scan_ready}, 32'd0);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        reset_n = 1;
        @(negedge clk);

        // Frame capture
        avl_wr(2'd3, 32'd4);
        avl_wr(2'd2, 32'd1);
        scan_valid = 1;
        for (int i = 0; i < 4; i++) begin
            scan_data = tbl[i];
            @(negedge clk);
        end
        scan_valid = 0;
        chk("frame_ready_drop", {31'd0, scan_ready}, 32'd0);
        avl_rd(2'd1, d);
        chk("frame_status", d, 32'h0000_0410);
        for (int i = 0; i < 4; i++) begin
            avl_rd(2'd0, d);
            chk("frame_data", d, {24'd0, tbl[i]});
        end

        // Underflow
        avl_rd(2'd0, d);
        chk("udf_data", d, 32'd0);
        avl_rd(2'd1, d);
        chk("udf_status", d, 32'h0000_0019);
        avl_wr(2'd1, 32'h1C);
        avl_rd(2'd1, d);
        chk("flags_cleared", d, 32'h0000_0001);

        // Fill and overflow
        avl_wr(2'd3, 32'd0);
        avl_wr(2'd2, 32'd1);
        scan_valid = 1;
        for (int i = 0; i < 17; i++) begin
            scan_data = 8'hA0 + 8'(i);
            @(negedge clk);
        end
        scan_valid = 0;
        chk("full_ready", {31'd0, scan_ready}, 32'd0);
        avl_rd(2'd1, d);
        chk("full_status", d, 32'h0000_1026);
        avl_wr(2'd1, 32'h4);
        avl_rd(2'd1, d);
        chk("ovf_cleared", d, 32'h0000_1022);
        for (int i = 0; i < 16; i++) begin
            avl_rd(2'd0, d);
            chk("drain_data", d, 32'hA0 + 32'(i));
        end

        // Simultaneous push and pop
        scan_valid = 1;
        for (int i = 1; i <= 3; i++) begin
            scan_data = 8'(i);
            @(negedge clk);
        end
        scan_data = 8'h5A;
        avl_rd(2'd0, d);
        scan_valid = 0;
        chk("pp_head", d, 32'd1);
        avl_rd(2'd1, d);
        chk("pp_status", d, 32'h0000_0320);
        avl_rd(2'd0, d); chk("pp_d1", d, 32'd2);
        avl_rd(2'd0, d); chk("pp_d2", d, 32'd3);
        avl_rd(2'd0, d); chk("pp_d3", d, 32'h5A);

        // Flush beats push, and enable=0 returns to IDLE
        scan_valid = 1;
        for (int i = 0; i < 5; i++) begin
            scan_data = 8'h61 + 8'(i);
            @(negedge clk);
        end
        scan_data = 8'h77;
        avl_wr(2'd2, 32'h8000_0000);
        scan_valid = 0;
        avl_rd(2'd1, d);
        chk("flush_status", d, 32'h0000_0001);
        avl_rd(2'd0, d);
        chk("flush_dropped", d, 32'd0);
        avl_wr(2'd1, 32'h1C);
        avl_wr(2'd2, 32'd0);
        chk("idle_ready", {31'd0, scan_ready}, 32'd0);

        // Interrupt
        avl_wr(2'd3, 32'd2);
        avl_wr(2'd2, 32'd3);
        scan_valid = 1;
        scan_data = 8'hC1; @(negedge clk);
        scan_data = 8'hC2; @(negedge clk);
        scan_valid = 0;
        chk("irq_at_done", {31'd0, irq}, 32'd0);
        @(negedge clk);
`ifdef SCANNER_RX_IRQ_EN
        chk("irq_after_done", {31'd0, irq}, 32'd1);
        avl_rd(2'd2, d);
        chk("ctrl_read", d, 32'd3);
`else
        chk("irq_after_done", {31'd0, irq}, 32'd0);
        avl_rd(2'd2, d);
        chk("ctrl_read", d, 32'd1);
`endif
        avl_wr(2'd1, 32'h10);
        @(negedge clk);
        chk("irq_cleared", {31'd0, irq}, 32'd0);

        // Reset mid-frame
        avl_wr(2'd3, 32'd0);
        avl_wr(2'd2, 32'd1);
        scan_valid = 1;
        scan_data = 8'hD1;
        @(negedge clk);
        #2 reset_n = 0;
        #1;
        chk("midrst_ready", {31'd0, scan_ready}, 32'd0);
        chk("midrst_readdata", readdata, 32'd0);
        chk("midrst_irq", {31'd0, irq}, 32'd0);
        scan_valid = 0;
        @(negedge clk);
        reset_n = 1;
        @(negedge clk);
        avl_rd(2'd1, d);
        chk("post_rst_status", d, 32'h0000_0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scanner_rx_ctrl.md
Name: scanner_rx_ctrl

Overview:
Capture controller for the 8-bit scanner byte stream that feeds the Nios II.
- Accepts bytes from the scanner over a valid/ready handshake and buffers them in a small FIFO.
- Sequences capture of fixed-length frames.
- Exposes data, status, control and frame-length registers on a 2-bit-address Avalon-MM slave with 1-cycle read latency.
- Sits between the scanner logic and the system interconnect.

Parameters:
DEPTH, 16, FIFO entries; power of two, 4..256
DATA_W, 8, scanner byte width; fixed at 8 for register packing

Ports:
clk  in  1  system clock, all logic rising-edge
reset_n  in  1  asynchronous active-low reset
scan_data  in  8  scanner byte
scan_valid  in  1  scanner byte valid
scan_ready  out  1  controller can accept a byte
address  in  2  Avalon register select
chipselect  in  1  Avalon slave select
read  in  1  Avalon read strobe
write  in  1  Avalon write strobe
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
irq  out  1  interrupt request, level

Behaviour:
Interface: one clock `clk`; `reset_n` is asynchronous and active-low.

Reset:
- readdata=0, scan_ready=0, irq=0.
- FSM=IDLE, FIFO empty, all flags 0, frame_len=0, byte counter 0.

Handshake and FIFO:
- Push occurs when scan_valid & scan_ready.
- scan_ready = (state==RUN) & ~full; driven from registers only.
- FIFO count updates the cycle after push/pop.
- Simultaneous push and pop: both take effect; count is unchanged.

Registers:
- Reads: readdata is valid the cycle after chipselect&read; unused bits read 0.
- Addr 0 DATA, read only:
  - Returns the head byte zero-extended and pops it.
  - If the FIFO is empty: returns 0, no pop, sets sticky UNDERFLOW.
  - Writes are ignored.
- Addr 1 STATUS:
  - [0] empty, [1] full, [2] OVERFLOW sticky, [3] UNDERFLOW sticky, [4] DONE, [5] running, [16:8] count.
  - Writing 1 to bit 2, 3 or 4 clears that bit.
- Addr 2 CONTROL:
  - [0] enable, [1] irq_en.
  - Writing bit 31 = 1 flushes the FIFO (count=0) that cycle; flush beats a concurrent push.
- Addr 3 FRAME_LEN: [7:0] bytes per frame; 0 means unlimited.

FSM:
- IDLE -> RUN: CONTROL write with enable=1. Clears the byte counter and DONE.
- RUN -> DONE: the accepted byte makes the counter equal frame_len (frame_len≠0). scan_ready drops the next cycle and DONE sets.
- DONE -> RUN: CONTROL write with enable=1, which restarts the frame.
- Any state -> IDLE: CONTROL write with enable=0. FIFO contents are kept.

Boundaries:
- OVERFLOW sets when scan_valid=1 in RUN while full. The byte is not taken.
- Byte counter is 8 bits. In unlimited mode it wraps with no effect.
- FRAME_LEN written during RUN takes effect on the next compare.
- Reset mid-frame returns everything to reset values immediately.
- A write to CONTROL and a pop in the same cycle are independent.

Optional Feature:
Macro SCANNER_RX_IRQ_EN.
- Defined: irq = irq_en & (DONE | OVERFLOW), registered, so it asserts one cycle after the flag sets. It clears once software clears the flags or irq_en.
- Undefined:
  - irq tied 0.
  - CONTROL[1] is write-ignored and reads 0.
  - No irq logic is synthesised.

Decomposition:
- Package scanner_rx_pkg:
  - Register offsets ADDR_DATA/STATUS/CONTROL/FRAME_LEN.
  - STATUS and CONTROL bit indices.
  - FSM state enum {IDLE, RUN, DONE}.
- Sub-module scanner_rx_fifo:
  - Synchronous FIFO with push, pop, flush, head data, count, full, empty.
  - Parameterised by DEPTH and DATA_W.
  - Same clk/reset_n.

Test Plan:
- Frame capture: reset; write FRAME_LEN=4, CONTROL=1; stream 0x11,0x22,0x33,0x44 with scan_valid held -> scan_ready low the cycle after the 4th byte; STATUS = DONE=1, count=4; DATA reads 0x11,0x22,0x33,0x44 in order.
- Fill and overflow: DEPTH=16, FRAME_LEN=0, enable, 17 valid bytes with no reads -> full=1, count=16, scan_ready=0, OVERFLOW=1; write STATUS=0x4 -> OVERFLOW=0.
- Underflow: read DATA on empty FIFO -> readdata=0, UNDERFLOW=1, count stays 0.
- Simultaneous push and pop: count=3; push 0x5A in the same cycle as a DATA read -> count stays 3; 0x5A is returned after the older 3 bytes.
- Flush and disable: with count=5, write CONTROL=0x8000_0000 while pushing -> count=0 next cycle and the pushed byte is dropped; write CONTROL=0 -> scan_ready=0, state IDLE.
- IRQ (SCANNER_RX_IRQ_EN defined): CONTROL=0x3, FRAME_LEN=2, push 2 bytes -> irq=1 one cycle after DONE; clear DONE -> irq=0. With the macro undefined -> irq stays 0.
